// File: rtl/montgomery_mul_param.sv
// Word-serial Montgomery multiplier: result = u*v*2^-SIZE mod N.
// Operands, N and N' are loaded word by word from the bus while idle.
module montgomery_mul_param #(
    parameter  int unsigned SIZE = 1024,
    parameter  int unsigned WORD = 64,
    localparam int unsigned S    = SIZE / WORD,
    localparam int unsigned IDXW = (S > 1) ? $clog2(S) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load_valid,
    input  logic [1:0]      load_sel,
    input  logic [IDXW-1:0] load_idx,
    input  logic [WORD-1:0] bus,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [SIZE-1:0] result
);

    localparam int unsigned TW = SIZE + 2 * WORD;
    localparam int unsigned CW = WORD + 2;
    localparam int unsigned DW = 2 * WORD;
    localparam int unsigned RW = 2 * WORD + 2;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REJECT,
        MCALC,
        ROW,
        SHIFT,
        FINAL
    } state_t;

    state_t state_q, state_d;

    logic [SIZE-1:0] u_q, v_q, n_q;
    logic [WORD-1:0] np_q;
    logic [TW-1:0]   t_q;
    logic [IDXW-1:0] i_q, j_q;
    logic [WORD-1:0] m_q;
    logic [CW-1:0]   c_q;
    logic [SIZE-1:0] result_q;
    logic            done_q, err_q;
    logic            done_d, err_d;

    logic [WORD-1:0] u_i, v_j, n_j, t_j;
    logic [DW-1:0]   prod_uv, prod_mn;
    logic [WORD-1:0] m_calc;
    logic [RW-1:0]   row_sum;
    logic [DW-1:0]   t_hi;
    logic            operands_bad;
    logic            t_ge_n;
    logic [SIZE-1:0] t_red;
    logic            last_i, last_j;

    assign u_i = u_q[i_q*WORD +: WORD];
    assign v_j = v_q[j_q*WORD +: WORD];
    assign n_j = n_q[j_q*WORD +: WORD];
    assign t_j = t_q[j_q*WORD +: WORD];

    // j is held at 0 during MCALC, so the row multiplier also yields u_i*v_0 for m.
    assign prod_uv = {{WORD{1'b0}}, u_i} * {{WORD{1'b0}}, v_j};
    assign prod_mn = {{WORD{1'b0}}, m_q} * {{WORD{1'b0}}, n_j};
    assign m_calc  = (t_j + prod_uv[WORD-1:0]) * np_q;
    assign row_sum = RW'(t_j) + RW'(prod_uv) + RW'(prod_mn) + RW'(c_q);
    assign t_hi    = t_q[TW-1:SIZE] + DW'(c_q);

    assign operands_bad = ~n_q[0] | (u_q >= n_q) | (v_q >= n_q);
    assign t_ge_n       = (t_q >= TW'(n_q));
    assign t_red        = t_ge_n ? (t_q[SIZE-1:0] - n_q) : t_q[SIZE-1:0];
    assign last_i       = (i_q == IDXW'(S - 1));
    assign last_j       = (j_q == IDXW'(S - 1));

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE:    if (start) state_d = CHECK;
            CHECK:   state_d = operands_bad ? REJECT : MCALC;
            // Holds the reject outcome one cycle so rejection always reports two cycles after start.
            REJECT: begin
                state_d = IDLE;
                done_d  = 1'b1;
                err_d   = 1'b1;
            end
            MCALC:   state_d = ROW;
            ROW:     if (last_j) state_d = SHIFT;
            SHIFT:   state_d = last_i ? FINAL : MCALC;
            FINAL: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            u_q      <= '0;
            v_q      <= '0;
            n_q      <= '0;
            np_q     <= '0;
            t_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            m_q      <= '0;
            c_q      <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        case (load_sel)
                            2'd0: u_q[load_idx*WORD +: WORD] <= bus;
                            2'd1: v_q[load_idx*WORD +: WORD] <= bus;
                            2'd2: n_q[load_idx*WORD +: WORD] <= bus;
                            2'd3: np_q <= bus;
                            default: ;
                        endcase
                    end
                end
                CHECK: begin
                    t_q <= '0;
                    i_q <= '0;
                    j_q <= '0;
                end
                MCALC: begin
                    m_q <= m_calc;
                    c_q <= '0;
                end
                ROW: begin
                    t_q[j_q*WORD +: WORD] <= row_sum[WORD-1:0];
                    c_q <= row_sum[RW-1:WORD];
                    j_q <= last_j ? '0 : j_q + 1'b1;
                end
                SHIFT: begin
                    // Carry folds into the top two words in the same step as the word shift.
                    t_q <= {{WORD{1'b0}}, t_hi, t_q[SIZE-1:WORD]};
                    i_q <= i_q + 1'b1;
                end
                FINAL: result_q <= t_red;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/montgomery_mul_param.md
Name: montgomery_mul_param

Overview:
- Parametrised word-serial Montgomery modular multiplier: result = u·v·R⁻¹ mod N, with R = 2^SIZE.
- Successor to the fixed-1024-bit unprotected core. Adds runtime-loadable modulus N and N', a start/busy/done handshake, a fixed deterministic latency, and an operand-range/odd-modulus check that raises err instead of computing.
- Sits between the 64-bit operand bus and the fault-detection wrapper.

Parameters:
- SIZE, 1024, operand/modulus width in bits; must be a multiple of WORD.
- WORD, 64, datapath word width (b = 2^WORD).
- S, SIZE/WORD, word count; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  write bus word into the operand store this cycle.
- load_sel  in  2  target: 0=u, 1=v, 2=N, 3=N' (load_idx ignored for N').
- load_idx  in  clog2(S)  word index; 0 = least-significant word.
- bus  in  WORD  load data.
- start  in  1  begin operation (single-cycle pulse, sampled when idle).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at operation end.
- err  out  1  valid with done; 1 = operands rejected, result unchanged.
- result  out  SIZE  final value; held stable until the next accepted start.

Behaviour:
- Reset (async, any state): busy=0, done=0, err=0, result=0. u, v, N, N', t, counters and FSM return to IDLE. A reset mid-operation aborts with no done pulse.
- Loads: accepted only in IDLE. load_valid while busy is ignored. Operand registers persist across operations.
- start in IDLE: go to CHECK. start while busy or in CHECK is ignored. start and load_valid in the same cycle: the load is applied, then CHECK sees the new value.
- CHECK (1 cycle): reject if N[0]==0, u>=N, or v>=N.
  - Reject: done=1, err=1 next cycle; result untouched; back to IDLE.
  - Pass: t=0, i=0, go to MCALC.
- MCALC (1 cycle): m = ((t0 + u_i·v_0) · N') mod 2^WORD. t0 = t[WORD-1:0]; u_i = word i of u.
- ROW (S cycles, j = 0..S-1):
  - {c, t_j} = t_j + u_i·v_j + m·N_j + c.
  - Carry c is WORD+2 bits and is cleared at row start.
  - One WORD×WORD product pair per cycle.
- SHIFT (1 cycle):
  - Fold c into t words S and S+1.
  - t = t >> WORD.
  - i = i+1; if i == S-1 go to FINAL, else MCALC.
- t register width is SIZE+2·WORD; no overflow is permitted by construction.
- FINAL (1 cycle): result = (t >= N) ? t−N : t, truncated to SIZE. Subtraction happens at most once. done=1, err=0 next cycle, then IDLE.
- Latency: the accepted start edge to the done pulse is exactly S·(S+2)+2 cycles on the success path and 2 cycles on the reject path. The bench checks these exactly.
- busy falls in the same cycle done rises.
- Correctness precondition: N' = −N⁻¹ mod 2^WORD. The block does not check N' (a wrong N' gives a wrong result with err=0).

Test Plan (SIZE=16, WORD=8, S=2, N=0xFFF1, N'=0xEF unless stated):
- Load u=0x000F, v=0x000F, start -> done exactly 10 cycles after start, err=0, result=0x000F (Montgomery form of 1·1).
- u=0x0001, v=0x0001 -> result=0xEEE1 (R⁻¹ mod N), err=0; u=0x0000 -> result=0x0000.
- u=0xFFF1 (==N) -> done 2 cycles after start, err=1, result keeps its previous value. Separately, N=0xFFF0 (even), valid u and v -> err=1.
- start pulses and load_valid writes to u during busy -> ignored: a single done after 10 cycles, result from the original operands; the next operation confirms u unchanged.
- reset_n low for 1 cycle mid-ROW -> all outputs 0 immediately, no done pulse. Reload, restart -> correct result.
- Default params (1024/64) with random u,v < N, 20 vectors vs a software model -> all match, latency 290 cycles each.
